mips_fetch: RTL and testbench

Instruction-fetch stage directly upstream of mips_decode in the multicycle MIPS datapath. It holds the fetch PC and runs a req/ack handshake with instruction memory. It presents one instruction at a time (inst, inst_pc) to the decode/execute side under a valid/ready handshake. It applies redirects produced from decode's control_type (branch/jump/jr target) and squashes any stale in-flight fetch.

---
 rtl/mips_fetch.sv | 138 +++++++++++++
 tb/tb_mips_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch
// Brief    : Instruction-fetch stage: PC, imem req/ack, valid/ready to decode,
//            redirect handling with stale-fetch squash and alignment trap.
// Revision : 1.0  initial release
// ============================================================================
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [31:0] C_INST_BYTES = 32'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        align_err_q, align_err_d;

    logic        w_redir_ok;
    logic        w_redir_bad;

    assign w_redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            inst_q      <= 32'd0;
            inst_pc_q   <= 32'd0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            align_err_q <= align_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        align_err_d = align_err_q;

        case (state_q)
            S_REQ: begin
                if (w_redir_bad) begin
                    state_d     = S_ERR;
                    align_err_d = 1'b1;
                end else if (w_redir_ok && imem_ack) begin
                    // Returning word belongs to the squashed path; refetch at target.
                    req_addr_d = redirect_pc;
                    pc_d       = redirect_pc;
                end else if (w_redir_ok) begin
                    pc_d    = redirect_pc;
                    state_d = S_DRAIN;
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = req_addr_q;
                    pc_d      = req_addr_q + C_INST_BYTES;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir_bad) begin
                    state_d     = S_ERR;
                    align_err_d = 1'b1;
                end else if (w_redir_ok) begin
                    req_addr_d = redirect_pc;
                    pc_d       = redirect_pc;
                    state_d    = S_REQ;
                end else if (inst_ready) begin
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                // Old request must complete before the redirected fetch can issue.
                if (w_redir_bad) begin
                    state_d     = S_ERR;
                    align_err_d = 1'b1;
                end else begin
                    if (w_redir_ok) begin
                        pc_d = redirect_pc;
                    end
                    if (imem_ack) begin
                        req_addr_d = w_redir_ok ? redirect_pc : pc_q;
                        state_d    = S_REQ;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign imem_req   = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_addr  = req_addr_q;
    assign inst_valid = (state_q == S_HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign align_err  = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_fetch
// Brief    : Directed and randomized self-checking bench for mips_fetch.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, inst_valid, inst_ready, redirect, align_err;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;

    logic        w_req, w_ack, w_valid, w_ready, w_align;
    logic [31:0] w_addr, w_inst, w_inst_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_fetch dut (
        .clock      (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .align_err  (align_err)
    );

    mips_fetch #(.RESET_PC(32'hFFFFFFFC)) dut_w (
        .clock      (clk),
        .reset      (reset),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ack   (w_ack),
        .imem_rdata (32'hC0DE0001),
        .inst_valid (w_valid),
        .inst       (w_inst),
        .inst_pc    (w_inst_pc),
        .inst_ready (w_ready),
        .redirect   (1'b0),
        .redirect_pc(32'd0),
        .align_err  (w_align)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_req(input logic [31:0] a);
        chk("req_high", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = memf(a);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
    endtask

    task automatic check_hold(input logic [31:0] a);
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_inst_pc", inst_pc, a);
        chk("hold_inst", inst, memf(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_pending;
        int          wait_cnt, consumed;

        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0; w_ack = 1'b0; w_ready = 1'b0;
        step(); step();
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'h00400000);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back fetches with ready tied high
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_req(32'h00400000 + 32'(4 * i));
            check_hold(32'h00400000 + 32'(4 * i));
            step();
        end
        chk("seq_align", {31'd0, align_err}, 32'd0);

        // Backpressure for five cycles
        inst_ready = 1'b0;
        do_req(32'h0040000C);
        check_hold(32'h0040000C);
        for (int i = 0; i < 5; i++) begin
            step();
            check_hold(32'h0040000C);
        end
        inst_ready = 1'b1;
        step();
        chk("bp_req", {31'd0, imem_req}, 32'd1);
        chk("bp_addr", imem_addr, 32'h00400010);

        // Redirect beats ready in HOLD
        do_req(32'h00400010);
        check_hold(32'h00400010);
        redirect = 1'b1; redirect_pc = 32'h00400100;
        step();
        redirect = 1'b0;
        chk("hr_valid", {31'd0, inst_valid}, 32'd0);
        do_req(32'h00400100);
        check_hold(32'h00400100);
        step();

        // Redirect during a slow memory wait
        chk("dr_addr0", imem_addr, 32'h00400104);
        redirect = 1'b1; redirect_pc = 32'h00400200;
        step();
        redirect = 1'b0;
        chk("dr_req1", {31'd0, imem_req}, 32'd1);
        chk("dr_addr1", imem_addr, 32'h00400104);
        step();
        chk("dr_addr2", imem_addr, 32'h00400104);
        imem_ack = 1'b1; imem_rdata = memf(32'h00400104);
        step();
        imem_ack = 1'b0;
        chk("dr_valid", {31'd0, inst_valid}, 32'd0);
        do_req(32'h00400200);
        check_hold(32'h00400200);
        step();

        // Redirect coinciding with ack
        chk("ca_addr0", imem_addr, 32'h00400204);
        step();
        chk("ca_addr1", imem_addr, 32'h00400204);
        imem_ack = 1'b1; imem_rdata = memf(32'h00400204);
        redirect = 1'b1; redirect_pc = 32'h00400200;
        step();
        imem_ack = 1'b0; redirect = 1'b0;
        chk("ca_valid", {31'd0, inst_valid}, 32'd0);
        do_req(32'h00400200);
        check_hold(32'h00400200);

        // Misaligned redirect traps until reset
        redirect = 1'b1; redirect_pc = 32'h00400102;
        step();
        for (int i = 0; i < 12; i++) begin
            chk("err_align", {31'd0, align_err}, 32'd1);
            chk("err_req", {31'd0, imem_req}, 32'd0);
            chk("err_valid", {31'd0, inst_valid}, 32'd0);
            redirect    = 1'($urandom_range(0, 1));
            redirect_pc = 32'h00400000 | (32'($urandom_range(0, 255)) << 2);
            imem_ack    = 1'($urandom_range(0, 1));
            inst_ready  = 1'($urandom_range(0, 1));
            step();
        end
        redirect = 1'b0; imem_ack = 1'b0; inst_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("err_rst_align", {31'd0, align_err}, 32'd0);
        chk("err_rst_req", {31'd0, imem_req}, 32'd1);
        chk("err_rst_addr", imem_addr, 32'h00400000);

        // Top-of-address-space wrap
        chk("wrap_addr0", w_addr, 32'hFFFFFFFC);
        w_ack = 1'b1;
        step();
        w_ack = 1'b0; w_ready = 1'b1;
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_inst_pc", w_inst_pc, 32'hFFFFFFFC);
        step();
        chk("wrap_req", {31'd0, w_req}, 32'd1);
        chk("wrap_addr1", w_addr, 32'h00000000);

        // Reset in the middle of a memory wait
        do_req(32'h00400000);
        check_hold(32'h00400000);
        step();
        chk("mw_addr", imem_addr, 32'h00400004);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("mw_req", {31'd0, imem_req}, 32'd1);
        chk("mw_addr_rst", imem_addr, 32'h00400000);
        chk("mw_valid", {31'd0, inst_valid}, 32'd0);

        // Randomized traffic against a program-order reference
        exp_pc       = 32'h00400000;
        prev_pending = 1'b0;
        prev_addr    = 32'd0;
        wait_cnt     = int'($urandom_range(0, 3));
        consumed     = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_pending) begin
                chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_stable", imem_addr, prev_addr);
            end
            if (inst_valid) begin
                chk("rnd_valid_noreq", {31'd0, imem_req}, 32'd0);
                chk("rnd_inst_pc", inst_pc, exp_pc);
                chk("rnd_inst", inst, memf(inst_pc));
            end
            if (cyc % 100 == 0) chk("rnd_align", {31'd0, align_err}, 32'd0);

            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 32'h00400000 | (32'($urandom_range(0, 1023)) << 2);
            inst_ready  = ($urandom_range(0, 2) != 0);
            if (imem_req) begin
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memf(imem_addr);
                    wait_cnt   = int'($urandom_range(0, 3));
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt--;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end

            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            step();
        end
        chk("rnd_progress", {31'd0, (consumed >= 100)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
